// File: rtl/bpred_pkg.sv
// Shared types and helpers for the tournament branch predictor.
//   btb_entry_t : one BTB way (tag, target, valid); tag and target fields are sized for
//                 RV32 and hold zero-extended values when the configuration is narrower.
//   pc_lsb      : number of ignored low PC bits for a given instruction width.
//   tag_w       : BTB tag width for a given PC width, instruction width and set count.
//   sat_upd     : saturating up/down step of a counter of the given width.
package bpred_pkg;

  localparam int unsigned BTB_FIELD_W = 32;

  typedef struct packed {
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
    logic                   vld;
  } btb_entry_t;

  function automatic int unsigned pc_lsb(input int unsigned inst_width);
    return $clog2(inst_width / 8);
  endfunction

  function automatic int unsigned tag_w(input int unsigned pc_width,
                                        input int unsigned inst_width,
                                        input int unsigned set_w);
    return pc_width - pc_lsb(inst_width) - set_w;
  endfunction

  function automatic logic [7:0] sat_upd(input logic [7:0] cnt, input logic up,
                                         input int unsigned width);
    logic [7:0] cnt_max;
    cnt_max = 8'((32'd1 << width) - 32'd1);
    if (up) return (cnt == cnt_max) ? cnt : cnt + 8'd1;
    else    return (cnt == 8'd0) ? cnt : cnt - 8'd1;
  endfunction

endpackage

// File: rtl/bpred_tournament_if.sv
// Fetch/execute-side bus of the tournament predictor.
//   master : fetch PC, fetch valid and resolved-branch training (drives i_*, reads o_*)
//   slave  : predictor side (reads i_*, drives hit, prediction, next PC, GHR snapshot)
interface bpred_tournament_if #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned GHR_W    = 10
);
  logic [PC_WIDTH-1:0] i_pc;
  logic                i_fetch_vld;
  logic                o_hit;
  logic                o_taken;
  logic [PC_WIDTH-1:0] o_next_pc;
  logic                o_glb_taken;
  logic                o_loc_taken;
  logic [GHR_W-1:0]    o_ghr_snap;
  logic                i_upd_vld;
  logic [PC_WIDTH-1:0] i_upd_pc;
  logic [PC_WIDTH-1:0] i_upd_br_addr;
  logic                i_upd_taken;
  logic                i_upd_hit;
  logic                i_upd_pred_glb;
  logic                i_upd_pred_loc;
  logic [GHR_W-1:0]    i_upd_ghr_snap;
  logic                i_upd_mispred;

  modport master (
    output i_pc, i_fetch_vld, i_upd_vld, i_upd_pc, i_upd_br_addr, i_upd_taken, i_upd_hit,
           i_upd_pred_glb, i_upd_pred_loc, i_upd_ghr_snap, i_upd_mispred,
    input  o_hit, o_taken, o_next_pc, o_glb_taken, o_loc_taken, o_ghr_snap
  );

  modport slave (
    input  i_pc, i_fetch_vld, i_upd_vld, i_upd_pc, i_upd_br_addr, i_upd_taken, i_upd_hit,
           i_upd_pred_glb, i_upd_pred_loc, i_upd_ghr_snap, i_upd_mispred,
    output o_hit, o_taken, o_next_pc, o_glb_taken, o_loc_taken, o_ghr_snap
  );
endinterface

// File: rtl/btb_sa.sv
// Set-associative BTB with round-robin replacement.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_pc           : lookup PC; o_hit / o_target are combinational
//   i_ins_vld      : install (taken branch resolved) of i_ins_pc -> i_ins_target
module btb_sa
  import bpred_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned BTB_SET_W  = 7,
  parameter int unsigned BTB_WAYS   = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_hit,
  output logic [PC_WIDTH-1:0] o_target,
  input  logic                i_ins_vld,
  input  logic [PC_WIDTH-1:0] i_ins_pc,
  input  logic [PC_WIDTH-1:0] i_ins_target
);
  localparam int unsigned PC_LSB = pc_lsb(INST_WIDTH);
  localparam int unsigned TAG_W  = tag_w(PC_WIDTH, INST_WIDTH, BTB_SET_W);
  localparam int unsigned SETS   = 1 << BTB_SET_W;
  localparam int unsigned WAY_W  = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;

  btb_entry_t       r_btb [SETS][BTB_WAYS];
  logic [WAY_W-1:0] r_rr  [SETS];

  logic [BTB_SET_W-1:0]   w_set, w_iset;
  logic [BTB_FIELD_W-1:0] w_tag, w_itag;
  logic                   w_match, w_free, w_evict;
  logic [WAY_W-1:0]       w_match_way, w_free_way, w_way, w_rr_nxt;
  logic                   w_unused;

  assign w_set    = i_pc[PC_LSB +: BTB_SET_W];
  assign w_iset   = i_ins_pc[PC_LSB +: BTB_SET_W];
  assign w_tag    = BTB_FIELD_W'(i_pc[PC_WIDTH-1 -: TAG_W]);
  assign w_itag   = BTB_FIELD_W'(i_ins_pc[PC_WIDTH-1 -: TAG_W]);
  assign w_unused = ^{i_pc[PC_LSB-1:0], i_ins_pc[PC_LSB-1:0]};

  always_comb begin
    o_hit    = 1'b0;
    o_target = '0;
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (r_btb[w_set][w].vld && r_btb[w_set][w].tag == w_tag) begin
        o_hit    = 1'b1;
        o_target = r_btb[w_set][w].target[PC_WIDTH-1:0];
      end
    end
  end

  // Scan downwards so the lowest-index invalid way wins.
  always_comb begin
    w_match     = 1'b0;
    w_match_way = '0;
    w_free      = 1'b0;
    w_free_way  = '0;
    for (int w = BTB_WAYS - 1; w >= 0; w--) begin
      if (r_btb[w_iset][w].vld && r_btb[w_iset][w].tag == w_itag) begin
        w_match     = 1'b1;
        w_match_way = WAY_W'(w);
      end
      if (!r_btb[w_iset][w].vld) begin
        w_free     = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
    w_evict  = !w_match && !w_free;
    w_way    = w_match ? w_match_way : (w_free ? w_free_way : r_rr[w_iset]);
    w_rr_nxt = (32'(r_rr[w_iset]) == BTB_WAYS - 1) ? '0 : r_rr[w_iset] + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < BTB_WAYS; w++) r_btb[s][w] <= '0;
      end
    end else if (i_ins_vld) begin
      r_btb[w_iset][w_way] <= '{tag: w_itag, target: BTB_FIELD_W'(i_ins_target), vld: 1'b1};
      // Pointer advances only when a live entry is displaced.
      if (w_evict) r_rr[w_iset] <= w_rr_nxt;
    end
  end
endmodule

// File: rtl/bpred_tournament.sv
// Tournament branch predictor: BTB + gshare global PHT + PC-indexed local PHT + chooser.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : fetch lookup (i_pc, i_fetch_vld -> o_hit, o_taken, o_next_pc, component
//                  predictions, o_ghr_snap) and execute-stage training (i_upd_*)
module bpred_tournament
  import bpred_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned BTB_SET_W  = 7,
  parameter int unsigned BTB_WAYS   = 2,
  parameter int unsigned GHR_W      = 10,
  parameter int unsigned LOC_PHT_W  = 8,
  parameter int unsigned CNT_BITS   = 2,
  parameter int unsigned CHO_BITS   = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  bpred_tournament_if.slave  bus
);
  localparam int unsigned PC_LSB = pc_lsb(INST_WIDTH);
  localparam int unsigned GPHT_N = 1 << GHR_W;
  localparam int unsigned LPHT_N = 1 << LOC_PHT_W;
  localparam int unsigned CHO_N  = 1 << BTB_SET_W;

  logic [CNT_BITS-1:0] r_gpht [GPHT_N];
  logic [CNT_BITS-1:0] r_lpht [LPHT_N];
  logic [CHO_BITS-1:0] r_cho  [CHO_N];
  logic [GHR_W-1:0]    r_ghr;

  logic                 w_hit, w_glb, w_loc, w_use_glb, w_taken, w_glb_ok, w_loc_ok;
  logic [PC_WIDTH-1:0]  w_target;
  logic [GHR_W-1:0]     w_gidx, w_ugidx;
  logic [LOC_PHT_W-1:0] w_lidx, w_ulidx;
  logic [BTB_SET_W-1:0] w_cidx, w_ucidx;

  btb_sa #(
    .PC_WIDTH  (PC_WIDTH),
    .INST_WIDTH(INST_WIDTH),
    .BTB_SET_W (BTB_SET_W),
    .BTB_WAYS  (BTB_WAYS)
  ) u_btb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pc        (bus.i_pc),
    .o_hit       (w_hit),
    .o_target    (w_target),
    .i_ins_vld   (bus.i_upd_vld & bus.i_upd_taken),
    .i_ins_pc    (bus.i_upd_pc),
    .i_ins_target(bus.i_upd_br_addr)
  );

  assign w_gidx    = r_ghr ^ bus.i_pc[PC_LSB +: GHR_W];
  assign w_lidx    = bus.i_pc[PC_LSB +: LOC_PHT_W];
  assign w_cidx    = bus.i_pc[PC_LSB +: BTB_SET_W];
  assign w_glb     = r_gpht[w_gidx][CNT_BITS-1];
  assign w_loc     = r_lpht[w_lidx][CNT_BITS-1];
  assign w_use_glb = r_cho[w_cidx][CHO_BITS-1];
  assign w_taken   = w_hit & (w_use_glb ? w_glb : w_loc);

  assign bus.o_hit       = w_hit;
  assign bus.o_taken     = w_taken;
  assign bus.o_glb_taken = w_hit & w_glb;
  assign bus.o_loc_taken = w_hit & w_loc;
  assign bus.o_next_pc   = w_taken ? w_target : bus.i_pc + PC_WIDTH'(INST_WIDTH / 8);
  assign bus.o_ghr_snap  = r_ghr;

  // Training uses the history that travelled with the branch, never the live GHR.
  assign w_ugidx  = bus.i_upd_ghr_snap ^ bus.i_upd_pc[PC_LSB +: GHR_W];
  assign w_ulidx  = bus.i_upd_pc[PC_LSB +: LOC_PHT_W];
  assign w_ucidx  = bus.i_upd_pc[PC_LSB +: BTB_SET_W];
  assign w_glb_ok = bus.i_upd_pred_glb == bus.i_upd_taken;
  assign w_loc_ok = bus.i_upd_pred_loc == bus.i_upd_taken;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ghr <= '0;
    end else if (bus.i_upd_vld && bus.i_upd_mispred) begin
      // Repair beats a same-cycle fetch; that fetch's history bit is dropped.
      r_ghr <= {bus.i_upd_ghr_snap[GHR_W-2:0], bus.i_upd_taken};
    end else if (bus.i_fetch_vld && w_hit) begin
      r_ghr <= {r_ghr[GHR_W-2:0], w_taken};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < GPHT_N; i++) r_gpht[i] <= CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
      for (int i = 0; i < LPHT_N; i++) r_lpht[i] <= CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
      for (int i = 0; i < CHO_N; i++)  r_cho[i]  <= CHO_BITS'(1 << (CHO_BITS - 1));
    end else if (bus.i_upd_vld) begin
      r_gpht[w_ugidx] <= CNT_BITS'(sat_upd(8'(r_gpht[w_ugidx]), bus.i_upd_taken, CNT_BITS));
      r_lpht[w_ulidx] <= CNT_BITS'(sat_upd(8'(r_lpht[w_ulidx]), bus.i_upd_taken, CNT_BITS));
      // Chooser moves toward whichever component alone was right.
      if (bus.i_upd_hit && (w_glb_ok != w_loc_ok)) begin
        r_cho[w_ucidx] <= CHO_BITS'(sat_upd(8'(r_cho[w_ucidx]), w_glb_ok, CHO_BITS));
      end
    end
  end
endmodule

// File: tb/tb_bpred_tournament.sv
// Directed scoreboard bench for bpred_tournament (default parameters).
module tb_bpred_tournament;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpred_tournament_if #(.PC_WIDTH(32), .GHR_W(10)) bus ();

  bpred_tournament #(
    .PC_WIDTH  (32),
    .INST_WIDTH(32),
    .BTB_SET_W (7),
    .BTB_WAYS  (2),
    .GHR_W     (10),
    .LOC_PHT_W (8),
    .CNT_BITS  (2),
    .CHO_BITS  (3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] npc;
    logic        glb;
    logic        loc;
    logic [9:0]  ghr;
  } exp_t;

  exp_t q[$];
  logic chk_vld = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented lookup, sampled mid-cycle.
  exp_t e;
  always @(negedge clk) begin
    if (chk_vld) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard: lookup presented with no expected entry");
      end else begin
        e = q.pop_front();
        cmp(e.name, "hit",      32'(bus.o_hit),       32'(e.hit));
        cmp(e.name, "taken",    32'(bus.o_taken),     32'(e.taken));
        cmp(e.name, "next_pc",  bus.o_next_pc,        e.npc);
        cmp(e.name, "glb",      32'(bus.o_glb_taken), 32'(e.glb));
        cmp(e.name, "loc",      32'(bus.o_loc_taken), 32'(e.loc));
        cmp(e.name, "ghr_snap", 32'(bus.o_ghr_snap),  32'(e.ghr));
      end
    end
  end

  task automatic idle_inputs();
    bus.i_pc           = '0;
    bus.i_fetch_vld    = 1'b0;
    bus.i_upd_vld      = 1'b0;
    bus.i_upd_pc       = '0;
    bus.i_upd_br_addr  = '0;
    bus.i_upd_taken    = 1'b0;
    bus.i_upd_hit      = 1'b0;
    bus.i_upd_pred_glb = 1'b0;
    bus.i_upd_pred_loc = 1'b0;
    bus.i_upd_ghr_snap = '0;
    bus.i_upd_mispred  = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic fetch, input string nm,
                      input logic hit, input logic taken, input logic [31:0] npc,
                      input logic glb, input logic loc, input logic [9:0] ghr);
    exp_t x;
    bus.i_pc        = pc;
    bus.i_fetch_vld = fetch;
    x = '{name: nm, hit: hit, taken: taken, npc: npc, glb: glb, loc: loc, ghr: ghr};
    q.push_back(x);
    chk_vld = 1'b1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] addr, input logic taken,
                     input logic hit, input logic pglb, input logic ploc,
                     input logic [9:0] snap, input logic mispred);
    bus.i_upd_vld      = 1'b1;
    bus.i_upd_pc       = pc;
    bus.i_upd_br_addr  = addr;
    bus.i_upd_taken    = taken;
    bus.i_upd_hit      = hit;
    bus.i_upd_pred_glb = pglb;
    bus.i_upd_pred_loc = ploc;
    bus.i_upd_ghr_snap = snap;
    bus.i_upd_mispred  = mispred;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.i_upd_vld     = 1'b0;
    bus.i_upd_mispred = 1'b0;
    bus.i_fetch_vld   = 1'b0;
    chk_vld           = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  localparam logic [31:0] P = 32'h1004;  // set 1, chooser 1, local 1, global pc bits 0x001

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    look(32'h100, 1'b0, "reset_lookup", 0, 0, 32'h104, 0, 0, 10'd0); step();

    // Install 0x200->0x400; same-cycle lookup sees the old (empty) entry
    upd(32'h200, 32'h400, 1, 0, 0, 0, 10'd0, 0);
    look(32'h200, 1'b0, "no_bypass", 0, 0, 32'h204, 0, 0, 10'd0); step();
    upd(32'h200, 32'h400, 1, 0, 0, 0, 10'd0, 0); step();
    upd(32'h200, 32'h400, 1, 0, 0, 0, 10'd0, 0); step();
    look(32'h200, 1'b0, "trained_hit", 1, 1, 32'h400, 1, 1, 10'd0); step();

    // Three branches into set 0: first is evicted, pointer moves to way 1
    upd(32'h400, 32'h1400, 1, 0, 0, 0, 10'd0, 0); step();
    upd(32'h600, 32'h1600, 1, 0, 0, 0, 10'd0, 0); step();
    look(32'h200, 1'b0, "evict_first",  0, 0, 32'h204,  0, 0, 10'd0); step();
    look(32'h400, 1'b0, "second_hit",   1, 1, 32'h1400, 1, 1, 10'd0); step();
    look(32'h600, 1'b0, "third_hit",    1, 1, 32'h1600, 1, 1, 10'd0); step();
    upd(32'h800, 32'h1800, 1, 0, 0, 0, 10'd0, 0); step();
    look(32'h400, 1'b0, "evict_second", 0, 0, 32'h404,  0, 0, 10'd0); step();
    look(32'h600, 1'b0, "keep_third",   1, 1, 32'h1600, 1, 1, 10'd0); step();
    look(32'h800, 1'b0, "fourth_hit",   1, 1, 32'h1800, 1, 1, 10'd0); step();

    // Speculative GHR and mispredict repair (gpht[0x181] pre-trained to weakly taken)
    upd(32'h600, 32'h1600, 1, 0, 0, 0, 10'h001, 0); step();
    look(32'h600, 1'b1, "ghr_fetch0", 1, 1, 32'h1600, 1, 1, 10'd0); step();
    look(32'h600, 1'b1, "ghr_fetch1", 1, 1, 32'h1600, 1, 1, 10'd1); step();
    upd(32'h600, 32'h1600, 0, 0, 0, 0, 10'b01, 1);
    look(32'h600, 1'b1, "ghr_fetch2", 1, 0, 32'h604, 0, 1, 10'd3); step();
    look(32'h100, 1'b1, "ghr_repaired",  0, 0, 32'h104, 0, 0, 10'b010); step();
    look(32'h100, 1'b0, "ghr_hold_miss", 0, 0, 32'h104, 0, 0, 10'b010); step();

    // Chooser: make global say taken and local say not-taken at P
    upd(P, 32'h2000, 1, 0, 0, 0, 10'd2, 0); step();
    upd(P, 32'h2000, 0, 0, 0, 0, 10'h3FF, 0); step();
    look(P, 1'b0, "cho_init", 1, 1, 32'h2000, 1, 0, 10'd2); step();
    for (int i = 0; i < 4; i++) begin
      upd(P, 32'h2000, 0, 1, 0, 1, 10'h3FF, 0); step();  // global right, local wrong
    end
    look(P, 1'b0, "cho_sat7", 1, 1, 32'h2000, 1, 0, 10'd2); step();
    upd(P, 32'h2000, 0, 1, 1, 0, 10'h3FF, 0); step();    // local right, global wrong
    look(P, 1'b0, "cho_6", 1, 1, 32'h2000, 1, 0, 10'd2); step();
    upd(P, 32'h2000, 0, 0, 1, 0, 10'h3FF, 0); step();    // no BTB hit: chooser holds
    upd(P, 32'h2000, 0, 1, 1, 0, 10'h3FF, 0); step();
    upd(P, 32'h2000, 0, 1, 1, 0, 10'h3FF, 0); step();
    look(P, 1'b0, "cho_4_nohit_held", 1, 1, 32'h2000, 1, 0, 10'd2); step();
    upd(P, 32'h2000, 0, 1, 1, 0, 10'h3FF, 0); step();
    look(P, 1'b0, "cho_3_local", 1, 0, P + 32'd4, 1, 0, 10'd2); step();

    // Asynchronous reset between edges
    look(P, 1'b0, "async_reset", 0, 0, P + 32'd4, 0, 0, 10'd0);
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    upd(P, 32'h2000, 1, 0, 0, 0, 10'h3FF, 0); step();
    look(P, 1'b0, "post_reset_counters", 1, 0, P + 32'd4, 0, 1, 10'd0); step();
    look(32'h600, 1'b0, "post_reset_btb", 0, 0, 32'h604, 0, 0, 10'd0); step();

    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bpred_tournament.md
# bpred_tournament

Parametrised tournament branch predictor for the fetch stage of the RV32I core. It provides an N-way set-associative BTB with round-robin replacement, a gshare global predictor with a speculatively updated history register and mispredict repair, a PC-indexed local predictor, and a per-PC chooser. Lookup is combinational in the fetch cycle. Training arrives from the execute stage when a branch resolves.

## Interface
Parameters:
- PC_WIDTH, 32, PC width
- INST_WIDTH, 32, instruction width; PC_LSB = $clog2(INST_WIDTH/8) low bits are ignored
- BTB_SET_W, 7, log2 of the number of BTB sets
- BTB_WAYS, 2, associativity; a power of two, 1..4
- GHR_W, 10, global history length; the global PHT has 2**GHR_W entries
- LOC_PHT_W, 8, log2 of the number of local PHT entries
- CNT_BITS, 2, width of the global and local saturating counters
- CHO_BITS, 3, width of the chooser counter; the chooser table has 2**BTB_SET_W entries

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_pc  in  PC_WIDTH  fetch PC
- i_fetch_vld  in  1  fetch accepted this cycle; advances the speculative GHR
- o_hit  out  1  BTB hit
- o_taken  out  1  final prediction
- o_next_pc  out  PC_WIDTH  predicted next PC
- o_glb_taken / o_loc_taken  out  1 each  component predictions, each gated by o_hit
- o_ghr_snap  out  GHR_W  GHR value used for this lookup; carried down the pipeline
- i_upd_vld  in  1  a branch resolved
- i_upd_pc, i_upd_br_addr  in  PC_WIDTH each  PC and target of the resolved branch
- i_upd_taken  in  1  actual outcome
- i_upd_hit, i_upd_pred_glb, i_upd_pred_loc  in  1 each  the o_hit / o_glb_taken / o_loc_taken values that travelled with the branch
- i_upd_ghr_snap  in  GHR_W  the o_ghr_snap value that travelled with the branch
- i_upd_mispred  in  1  redirect; qualified by i_upd_vld

## Operation
- Address split. Set index = pc[PC_LSB +: BTB_SET_W]. Tag = the remaining upper bits.
- Lookup (combinational).
  - o_hit = any valid way whose tag matches.
  - Global prediction = MSB of gpht[ghr ^ pc[PC_LSB +: GHR_W]].
  - Local prediction = MSB of lpht[pc[PC_LSB +: LOC_PHT_W]].
  - o_taken = o_hit & (chooser MSB ? global : local).
  - o_next_pc = o_taken ? target of the hit way : i_pc + INST_WIDTH/8, truncated to PC_WIDTH.
- Speculative GHR.
  - Priority 1: i_upd_vld & i_upd_mispred → ghr <= {i_upd_ghr_snap[GHR_W-2:0], i_upd_taken}.
  - Priority 2: otherwise, i_fetch_vld & o_hit → ghr <= {ghr[GHR_W-2:0], o_taken}.
  - Otherwise the GHR holds.
- PHT training, on i_upd_vld.
  - Global entry trained: index i_upd_ghr_snap ^ i_upd_pc bits. The live GHR is never used for training.
  - Local entry trained: indexed by i_upd_pc.
  - Each counter saturates at 0 and at 2**CNT_BITS-1.
- Chooser training, on i_upd_vld & i_upd_hit only.
  - Global correct and local wrong → increment, saturating at max.
  - Local correct and global wrong → decrement, saturating at 0.
  - Both correct or both wrong → hold.
- BTB install, on i_upd_vld & i_upd_taken. The way is chosen in this order:
  - a valid way with a matching tag, which is updated in place;
  - otherwise the lowest-index invalid way;
  - otherwise the way under the set's round-robin pointer, and the pointer then increments mod BTB_WAYS. The pointer moves only on this eviction case.
- Not-taken branches never allocate a BTB entry.
- Reset values:
  - all BTB valid bits and round-robin pointers = 0; ghr = 0;
  - every PHT counter = 2**(CNT_BITS-1)-1 (weakly not-taken);
  - every chooser counter = 2**(CHO_BITS-1) (weakly global).
- Outputs while in reset: o_hit = 0, o_taken = 0, o_next_pc = i_pc+4, o_ghr_snap = 0.

## Timing
- Lookup latency is 0 cycles.
- Every update becomes visible to lookups on the cycle after the update edge.
- If an update and a lookup hit the same entry in the same cycle, the lookup sees the old value. There is no bypass.
- A mispredict repair and a fetch in the same cycle: the repair wins and the fetch's history bit is dropped.
- i_rst asserted mid-operation clears all state immediately, with no dependence on the clock edge.

## Structure
- bpred_pkg holds:
  - typedef btb_entry_t {tag, target, vld};
  - the localparam functions for PC_LSB and TAG_W;
  - the function sat_upd(cnt, up, width).
- Sub-module btb_sa contains the set-associative arrays, the hit/way mux, and the replacement logic.
- The PHTs, chooser and GHR stay in bpred_tournament.

## Test plan
- Reset, then i_pc=0x100 → o_hit=0, o_taken=0, o_next_pc=0x104, o_ghr_snap=0.
- Install taken branch pc 0x200→0x400, then train taken twice → lookup at 0x200 gives o_hit=1, o_taken=1, o_next_pc=0x400.
- BTB_WAYS=2: install three taken branches mapping to one set (0x200, 0x200+2**9, 0x200+2**10). Result: the first is evicted, the second and third hit, and the pointer = 1. A fourth install evicts the second.
- Two fetch hits predicting taken, then a mispredict with i_upd_ghr_snap=0b01 and i_upd_taken=0, in the same cycle as another fetch hit → next-cycle ghr = 0b010.
- Global right / local wrong four times from reset (CHO_BITS=3): chooser goes 4→7 and saturates at 7. Then local right / global wrong once → 6. An update with i_upd_hit=0 leaves the chooser unchanged.
- Assert i_rst asynchronously between clock edges after training → o_hit falls to 0 the same cycle; all counters return to their reset values.
